// File: rtl/dac_serializer.sv
// -----------------------------------------------------------------------------
// dac_serializer
//
// Frames the mono effect-chain output into I2S-style DAC slots. A new sample
// is parked in a holding register. At the start of each left slot (DACLRCK
// falling) it is copied into the frame register, which is then shifted out
// MSB first in both the left and the right slot. The shift starts one BCLK
// after each DACLRCK edge. Underruns (no new sample for a left frame) and
// overruns (a sample replaced before it was framed) are counted with
// saturating counters.
//
// Parameters
//   DATA_W  sample width and number of serial bits per slot
//   CNT_W   width of the underrun / overrun counters
//
// Ports
//   i_clk           codec bit clock (BCLK); all logic on its rising edge
//   i_rst_n         asynchronous active-low reset
//   i_lrc           DACLRCK, synchronous to i_clk (0 = left, 1 = right)
//   i_en            serializer enable
//   i_valid         one-cycle strobe: i_data carries a new sample
//   i_data          signed mono sample
//   o_dacdat        registered serial DAC data, MSB first
//   o_busy          high while a slot is being shifted out
//   o_underrun_cnt  left frames that found no new sample
//   o_overrun_cnt   samples overwritten before being framed
// -----------------------------------------------------------------------------
module dac_serializer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_lrc,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_dacdat,
    output logic                     o_busy,
    output logic [CNT_W-1:0]         o_underrun_cnt,
    output logic [CNT_W-1:0]         o_overrun_cnt
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    logic                     lrc_r;
    logic                     lrc_armed;
    logic                     lrc_edge;
    logic                     lrc_fall;

    logic signed [DATA_W-1:0] hold_p0;
    logic                     fresh_p0;
    logic signed [DATA_W-1:0] frame_p1;

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx_p2;

    // ---- Stage 0: DACLRCK edge detect ----
    // lrc_armed masks the first cycle after reset, when lrc_r has not yet
    // seen a real DACLRCK value and a spurious edge would otherwise appear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_r     <= 1'b0;
            lrc_armed <= 1'b0;
        end else begin
            lrc_r     <= i_lrc;
            lrc_armed <= 1'b1;
        end
    end

    assign lrc_edge = lrc_armed & (i_lrc ^ lrc_r);
    assign lrc_fall = lrc_edge & ~i_lrc;

    // ---- Stage 0 -> 1: holding register and left-frame capture ----
    // A sample arriving in the same cycle as the left-slot start bypasses the
    // holding register so it is framed without counting an under/overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_p0        <= '0;
            fresh_p0       <= 1'b0;
            frame_p1       <= '0;
            o_underrun_cnt <= '0;
            o_overrun_cnt  <= '0;
        end else begin
            if (i_valid) begin
                hold_p0 <= i_data;
            end

            if (lrc_fall && i_en) begin
                fresh_p0 <= 1'b0;
                if (i_valid) begin
                    frame_p1 <= i_data;
                end else if (fresh_p0) begin
                    frame_p1 <= hold_p0;
                end else begin
                    o_underrun_cnt <= sat_inc(o_underrun_cnt);
                end
            end else if (i_valid) begin
                fresh_p0 <= 1'b1;
                if (fresh_p0 && i_en) begin
                    o_overrun_cnt <= sat_inc(o_overrun_cnt);
                end
            end
        end
    end

    // ---- Stage 1 -> 2: slot FSM and serial output ----
    // Every DACLRCK edge (re)starts a slot at the MSB, which also aborts a
    // slot that was cut short. The edge cycle itself drives 0 so the MSB
    // lands one BCLK after the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            idx_p2   <= IDX_MSB;
            o_dacdat <= 1'b0;
        end else if (!i_en) begin
            state    <= ST_IDLE;
            idx_p2   <= IDX_MSB;
            o_dacdat <= 1'b0;
        end else if (lrc_edge) begin
            state    <= ST_SHIFT;
            idx_p2   <= IDX_MSB;
            o_dacdat <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    o_dacdat <= frame_p1[idx_p2];
                    if (idx_p2 == '0) begin
                        state <= ST_PAD;
                    end else begin
                        idx_p2 <= idx_p2 - 1'b1;
                    end
                end
                ST_PAD: begin
                    o_dacdat <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    o_dacdat <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_dac_serializer
//
// Self-checking bench for dac_serializer. A reference model tracks samples,
// counters and the time since the last DACLRCK edge, and from that predicts
// o_dacdat / o_busy every cycle. Directed scenarios add checks against
// literal bit patterns and counter values, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_dac_serializer;

    localparam int DW = 16;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 lrc;
    logic                 en;
    logic                 valid;
    logic signed [DW-1:0] data;
    logic                 dacdat;
    logic                 busy;
    logic [CW-1:0]        und;
    logic [CW-1:0]        ovr;

    dac_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_lrc          (lrc),
        .i_en           (en),
        .i_valid        (valid),
        .i_data         (data),
        .o_dacdat       (dacdat),
        .o_busy         (busy),
        .o_underrun_cnt (und),
        .o_overrun_cnt  (ovr)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          cyc_n;
    bit          m_prev, m_armed, m_fresh, m_active;
    logic [15:0] m_hold, m_frame, m_word;
    int          m_und, m_ovr, m_k;
    bit          m_exp_dac, m_exp_busy;

    logic [15:0] cap;
    logic [15:0] slot_q[$];

    task automatic model_reset();
        m_prev = 0; m_armed = 0; m_fresh = 0; m_active = 0;
        m_hold = '0; m_frame = '0; m_word = '0;
        m_und = 0; m_ovr = 0; m_k = 0;
        m_exp_dac = 0; m_exp_busy = 0;
    endtask

    // Called at a rising edge with the inputs that the DUT samples there.
    task automatic model_update();
        bit edg, fall;
        int d;
        edg  = m_armed && (lrc != m_prev);
        fall = edg && !lrc;
        if (en && fall) begin
            if (valid)        m_frame = data;
            else if (m_fresh) m_frame = m_hold;
            else if (m_und < 255) m_und++;
            m_fresh = 0;
        end else if (valid) begin
            if (m_fresh && en && m_ovr < 255) m_ovr++;
            m_fresh = 1;
        end
        if (valid) m_hold = data;

        if (!en) m_active = 0;
        else if (edg) begin
            m_active = 1;
            m_k      = cyc_n;
            m_word   = m_frame;
        end
        m_prev  = lrc;
        m_armed = 1;

        d = cyc_n - m_k;
        m_exp_dac  = 0;
        m_exp_busy = 0;
        if (m_active) begin
            if (d >= 1 && d <= DW) m_exp_dac = m_word[DW-d];
            m_exp_busy = (d < DW);
        end
    endtask

    // One clock: model at the edge, compare 1 time unit later.
    task automatic step();
        int d;
        @(posedge clk);
        cyc_n++;
        if (rst_n) model_update();
        else       model_reset();
        #1;
        check_val("dacdat", dacdat, m_exp_dac);
        check_val("busy",   busy,   m_exp_busy);
        check_val("und",    und,    m_und);
        check_val("ovr",    ovr,    m_ovr);
        if (rst_n && m_active) begin
            d = cyc_n - m_k;
            if (d >= 1 && d <= DW) cap = {cap[14:0], dacdat};
            if (d == DW) slot_q.push_back(cap);
        end
    endtask

    task automatic run_lrc(input bit lvl, input int len,
                           input int v0, input int v1, input int v2,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        for (int c = 0; c < len; c++) begin
            lrc   = lvl;
            valid = (c == v0) || (c == v1) || (c == v2);
            if (c == v0)      data = d0;
            else if (c == v1) data = d1;
            else if (c == v2) data = d2;
            step();
        end
        valid = 1'b0;
    endtask

    task automatic idle_lrc(input bit lvl, input int len);
        run_lrc(lvl, len, -1, -1, -1, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        model_reset();
        #1;
        check_val("rst_dacdat", dacdat, 0);
        check_val("rst_busy",   busy,   0);
        check_val("rst_und",    und,    0);
        check_val("rst_ovr",    ovr,    0);
        step();
        step();
        rst_n = 1'b1;
        slot_q.delete();
    endtask

    initial begin
        cyc_n = 0;
        rst_n = 1'b1;
        lrc   = 1'b1;
        en    = 1'b1;
        valid = 1'b0;
        data  = '0;
        cap   = '0;
        model_reset();
        #2;
        do_reset();

        // S1: 8001 every frame, 64-clock frames
        run_lrc(1, 8, 3, -1, -1, 16'h8001, 16'h0, 16'h0);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 64; c++) begin
                lrc   = (c < 32) ? 1'b0 : 1'b1;
                valid = (c == 50);
                data  = 16'sh8001;
                step();
                check_val("s1_pat", dacdat, ((c % 32) == 1 || (c % 32) == 16) ? 1 : 0);
            end
        end
        valid = 1'b0;
        check_val("s1_und", und, 0);

        // S2: one sample then repeated underruns
        do_reset();
        run_lrc(1, 8, 2, -1, -1, 16'h1234, 16'h0, 16'h0);
        for (int f = 0; f < 4; f++) begin
            idle_lrc(0, 32);
            idle_lrc(1, 32);
        end
        check_val("s2_slots", slot_q.size(), 8);
        foreach (slot_q[i]) check_val("s2_word", slot_q[i], 16'h1234);
        check_val("s2_und", und, 3);

        // S3: three samples inside one frame
        do_reset();
        run_lrc(1, 8, 2, -1, -1, 16'h5555, 16'h0, 16'h0);
        idle_lrc(0, 32);
        run_lrc(1, 32, 5, 10, 15, 16'h0001, 16'h0002, 16'h7FFF);
        slot_q.delete();
        idle_lrc(0, 32);
        idle_lrc(1, 32);
        check_val("s3_slots", slot_q.size(), 2);
        foreach (slot_q[i]) check_val("s3_word", slot_q[i], 16'h7FFF);
        check_val("s3_ovr", ovr, 2);
        check_val("s3_und", und, 0);

        // S4: counter saturation
        do_reset();
        idle_lrc(1, 4);
        for (int i = 0; i < 300; i++) begin
            idle_lrc(0, 20);
            idle_lrc(1, 20);
            if (i == 253) check_val("s4_und254", und, 254);
        end
        check_val("s4_und_sat", und, 8'hFF);
        for (int i = 0; i < 300; i++) begin
            lrc   = 1'b1;
            valid = 1'b1;
            data  = 16'(i);
            step();
        end
        valid = 1'b0;
        check_val("s4_ovr_sat", ovr, 8'hFF);

        // S5: 10-clock slot aborted and restarted
        do_reset();
        run_lrc(1, 8, 2, -1, -1, 16'h4C3A, 16'h0, 16'h0);
        for (int c = 0; c < 10; c++) begin
            lrc = 1'b0;
            step();
            check_val("s5_busy_short", busy, 1);
            if (c >= 1) check_val("s5_short_bit", dacdat, (16'h4C3A >> (16 - c)) & 1);
        end
        for (int c = 0; c < 40; c++) begin
            lrc = 1'b1;
            step();
            if (c < 16) check_val("s5_busy_restart", busy, 1);
            if (c == 0) check_val("s5_abort", dacdat, 0);
            else if (c <= 16) check_val("s5_new_bit", dacdat, (16'h4C3A >> (16 - c)) & 1);
        end

        // S6: reset at bit 7, then enable off for two frames
        do_reset();
        run_lrc(1, 8, 2, -1, -1, 16'hF0F0, 16'h0, 16'h0);
        for (int c = 0; c < 10; c++) begin
            lrc = 1'b0;
            step();
        end
        check_val("s6_bit7", dacdat, 1);
        en = 1'b0;
        do_reset();
        check_val("s6_held_dac", dacdat, 0);
        idle_lrc(0, 22);
        run_lrc(1, 32, 5, -1, -1, 16'h8421, 16'h0, 16'h0);
        idle_lrc(0, 32);
        run_lrc(1, 32, 5, -1, -1, 16'h9001, 16'h0, 16'h0);
        idle_lrc(0, 32);
        idle_lrc(1, 10);
        en = 1'b1;
        for (int c = 0; c < 22; c++) begin
            lrc = 1'b1;
            step();
            check_val("s6_quiet", dacdat, 0);
        end
        for (int c = 0; c < 20; c++) begin
            lrc = 1'b0;
            step();
            if (c == 0) check_val("s6_edge", dacdat, 0);
            if (c == 1) check_val("s6_msb", dacdat, 1);
            if (c == 2) check_val("s6_b14", dacdat, 0);
        end
        check_val("s6_ovr", ovr, 0);
        check_val("s6_und", und, 0);

        // S7: randomized slot lengths, strobes and enable
        do_reset();
        en = 1'b1;
        idle_lrc(1, 4);
        begin
            int start;
            start = cyc_n;
            while (cyc_n - start < 4000) begin
                int len;
                len = $urandom_range(6, 40);
                for (int c = 0; c < len; c++) begin
                    lrc   = ~lrc;
                    lrc   = ~lrc;
                    valid = ($urandom_range(0, 15) == 0);
                    data  = 16'($urandom);
                    if ($urandom_range(0, 199) == 0) en = ~en;
                    step();
                end
                lrc = ~lrc;
            end
        end
        valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
